// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the FIFO packet framer.
package fifo_pkt_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        CSUM    = 1'b1
    } state_t;

    // Widest data word the checksum helper handles; callers zero-extend and truncate.
    localparam int unsigned CSUM_MAX_W = 64;

    // Word-index width able to hold 0..pkt_len.
    function automatic int unsigned idx_w(input int unsigned pkt_len);
        return $clog2(pkt_len + 1);
    endfunction

    function automatic logic [CSUM_MAX_W-1:0] csum_step(input logic [CSUM_MAX_W-1:0] acc,
                                                        input logic [CSUM_MAX_W-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/fifo_pkt_out_reg.sv
// One-entry valid/ready holding register for packet beats (data, sop, eop).
module fifo_pkt_out_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sop,
    input  logic              i_eop,
    input  logic              i_rdy,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_slot_free
);

    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_sop;
    logic              r_eop;

    assign o_slot_free = !r_vld || i_rdy;

    // i_load is only raised while o_slot_free is high, so a held beat is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_sop  <= i_sop;
            r_eop  <= i_eop;
        end else if (i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_sop  = r_sop;
    assign o_eop  = r_eop;

endmodule

// File: rtl/fifo_pkt_framer.sv
// Groups PKT_LEN FIFO words into packets and appends an XOR checksum beat.
// Optional idle timeout closing partial packets: define FIFO_PKT_TIMEOUT_EN.
module fifo_pkt_framer
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_vld,
    output logic              data_in_rdy,
    output logic [DATA_W-1:0] pkt_data,
    output logic              pkt_sop,
    output logic              pkt_eop,
    output logic              pkt_vld,
    input  logic              pkt_rdy,
    output logic [15:0]       pkt_count
);

    localparam int unsigned    IDX_W    = idx_w(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [DATA_W-1:0] r_acc, w_acc_nxt;
    logic [DATA_W-1:0] w_acc_base;
    logic [15:0]       r_pkt_count;

    logic              w_slot_free;
    logic              w_accept;
    logic              w_timeout;
    logic              w_load;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_ld_sop;
    logic              w_ld_eop;

`ifdef FIFO_PKT_TIMEOUT_EN
    logic [15:0] r_idle;

    assign w_timeout = (r_state == COLLECT) && (r_idx != '0) && (r_idle == 16'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (r_state != COLLECT || r_idx == '0 || w_accept || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 16'd1;
        end
    end
`else
    logic [15:0] w_timeout_unused;

    assign w_timeout_unused = 16'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    assign data_in_rdy = !rst && (r_state == COLLECT) && w_slot_free && !w_timeout;
    assign w_accept    = data_in_vld && data_in_rdy;
    // First word of a packet restarts the checksum rather than folding into stale state.
    assign w_acc_base  = (r_idx == '0) ? '0 : r_acc;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_load      = 1'b0;
        w_ld_data   = data_in;
        w_ld_sop    = 1'b0;
        w_ld_eop    = 1'b0;
        unique case (r_state)
            COLLECT: begin
                if (w_timeout) begin
                    w_state_nxt = CSUM;
                    w_idx_nxt   = '0;
                end else if (w_accept) begin
                    w_load    = 1'b1;
                    w_ld_sop  = (r_idx == '0);
                    w_acc_nxt = DATA_W'(csum_step(CSUM_MAX_W'(w_acc_base), CSUM_MAX_W'(data_in)));
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = CSUM;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            CSUM: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_ld_data   = r_acc;
                    w_ld_eop    = 1'b1;
                    w_acc_nxt   = '0;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_acc       <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            if (pkt_vld && pkt_rdy && pkt_eop) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign pkt_count = r_pkt_count;

    fifo_pkt_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_data      (w_ld_data),
        .i_sop       (w_ld_sop),
        .i_eop       (w_ld_eop),
        .i_rdy       (pkt_rdy),
        .o_vld       (pkt_vld),
        .o_data      (pkt_data),
        .o_sop       (pkt_sop),
        .o_eop       (pkt_eop),
        .o_slot_free (w_slot_free)
    );

endmodule
